uart_sync_fifo: RTL and testbench

Parametrised synchronous FIFO that buffers bytes between the UART datapath and the host side.
- Generalises the team's single-clock FIFO to any depth ≥ 2 (power of two not required) and any data width.
- Adds a registered read port, an occupancy count, programmable almost-full/almost-empty thresholds, sticky error flags and a synchronous flush.

---
 rtl/uart_fifo_pkg.sv | 12 +
 rtl/uart_fifo_mem.sv | 29 ++
 rtl/uart_sync_fifo.sv | 122 ++++++++++++
 tb/tb_uart_sync_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared defaults and helpers for the UART byte FIFO.
// Optional build macro: FIFO_PARITY_EN (per-entry even parity).
package uart_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// No reset on storage or read register; the owner masks stale output.
module uart_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO between UART datapath and host, any depth >= 2.
// Define FIFO_PARITY_EN to store and check even parity per entry.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    input  logic                          flush,
    input  logic                          clr_err,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          parity_err
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

`ifdef FIFO_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_THRESH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_next;
    logic          wr_acc, rd_acc;
    logic          data_ok;
    logic [MW-1:0] mem_wdata, mem_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // flush squashes both requests so it never raises a sticky error
    always_comb begin
        rd_acc     = rd_en & ~empty & ~flush;
        wr_acc     = wr_en & (~full | rd_acc) & ~flush;
        count_next = count + CW'(wr_acc) - CW'(rd_acc);
        if (flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            data_ok      <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
                if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            end
            count        <= count_next;
            full         <= (count_next == FULL_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            rd_valid     <= rd_acc;
            if (rd_acc) data_ok <= 1'b1;
            overflow  <= (wr_en & ~wr_acc & ~flush) | (overflow & ~clr_err);
            underflow <= (rd_en & empty & ~flush) | (underflow & ~clr_err);
        end
    end

    uart_fifo_mem #(
        .WIDTH (MW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (mem_wdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (mem_q)
    );

    // read register is unreset; show zero until the first real read
    assign rd_data = data_ok ? mem_q[DATA_WIDTH-1:0] : '0;

`ifdef FIFO_PARITY_EN
    assign mem_wdata  = {^wr_data, wr_data};
    assign parity_err = rd_valid
                      & ((^mem_q[DATA_WIDTH-1:0]) != mem_q[DATA_WIDTH]);
`else
    assign mem_wdata  = wr_data;
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo with a queue-based reference model.
module tb_uart_sync_fifo;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       flush;
    logic       clr_err;
    logic       full, empty, almost_full, almost_empty;
    logic [2:0] count;
    logic       overflow, underflow, parity_err;

    uart_sync_fifo #(
        .DATA_WIDTH    (8),
        .DEPTH         (5),
        .AFULL_THRESH  (4),
        .AEMPTY_THRESH (1)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .flush        (flush),
        .clr_err      (clr_err),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .parity_err   (parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         cq[$];
    logic [7:0] m_rd_data;
    logic       m_valid, m_ovf, m_udf, m_perr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic w, input logic [7:0] d,
                              input logic r, input logic f,
                              input logic c, input logic rs);
        bit was_empty, racc, wacc;
        if (!rs) begin
            q.delete();
            cq.delete();
            m_rd_data = 8'h00;
            m_valid   = 1'b0;
            m_perr    = 1'b0;
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
        end else if (f) begin
            q.delete();
            cq.delete();
            m_valid = 1'b0;
            m_perr  = 1'b0;
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            was_empty = (q.size() == 0);
            racc = r && !was_empty;
            wacc = w && (q.size() < 5 || racc);
            m_valid = racc;
            m_perr  = 1'b0;
            if (racc) begin
                m_rd_data = q.pop_front();
                m_perr    = cq.pop_front();
            end
            if (wacc) begin
                q.push_back(d);
                cq.push_back(1'b0);
            end
            if (w && !wacc) m_ovf = 1'b1;
            else if (c)     m_ovf = 1'b0;
            if (r && was_empty) m_udf = 1'b1;
            else if (c)         m_udf = 1'b0;
        end
    endtask

    task automatic compare();
        int n;
        n = q.size();
        chk("count", 32'(count), n);
        chk("full", 32'(full), 32'(n == 5));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= 4));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", 32'(rd_data), 32'(m_rd_data));
        chk("parity_err", 32'(parity_err), 32'(m_valid & m_perr));
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                       input logic f = 1'b0, input logic c = 1'b0,
                       input logic rs = 1'b1);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        reset   = rs;
        model_step(w, d, r, f, c, rs);
        @(posedge clock);
        #1;
        compare();
    endtask

    logic [4:0] ae_e, af_e, fl_e;

    initial begin
        wr_en = 0; wr_data = 0; rd_en = 0;
        flush = 0; clr_err = 0; reset = 0;
        ae_e = 5'b00001;
        af_e = 5'b11000;
        fl_e = 5'b10000;

        // reset
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_rd_data", 32'(rd_data), 0);

        // 1: fill and overflow
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'(8'h11 * (i + 1)), 0);
            chk("t1_count", 32'(count), i + 1);
            chk("t1_ae", 32'(almost_empty), 32'(ae_e[i]));
            chk("t1_af", 32'(almost_full), 32'(af_e[i]));
            chk("t1_full", 32'(full), 32'(fl_e[i]));
        end
        cyc(1, 8'h66, 0);
        chk("t1_overflow", 32'(overflow), 1);
        chk("t1_count5", 32'(count), 5);

        // 2: drain, underflow, clear
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1);
            chk("t2_valid", 32'(rd_valid), 1);
            chk("t2_data", 32'(rd_data), 32'(8'(8'h11 * (i + 1))));
        end
        chk("t2_empty", 32'(empty), 1);
        cyc(0, 0, 1);
        chk("t2_underflow", 32'(underflow), 1);
        chk("t2_valid0", 32'(rd_valid), 0);
        cyc(0, 0, 0, 0, 1);
        chk("t2_clr_ovf", 32'(overflow), 0);
        chk("t2_clr_udf", 32'(underflow), 0);

        // 3: interleaved traffic wraps pointers
        cyc(1, 8'h01, 0);
        for (int i = 2; i <= 12; i++) begin
            cyc(1, 8'(i), 1);
            chk("t3_order", 32'(rd_data), i - 1);
        end
        cyc(0, 0, 1);
        chk("t3_last", 32'(rd_data), 32'h0C);
        chk("t3_ovf", 32'(overflow), 0);
        chk("t3_udf", 32'(underflow), 0);

        // 4: simultaneous read/write while full
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h11 * (i + 1)), 0);
        cyc(1, 8'hAA, 1);
        chk("t4_data", 32'(rd_data), 32'h11);
        chk("t4_count", 32'(count), 5);
        chk("t4_ovf", 32'(overflow), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1);
        chk("t4_last", 32'(rd_data), 32'hAA);

        // 5: flush overrides requests, sticky flags kept
        cyc(0, 0, 1);
        cyc(1, 8'h31, 0);
        cyc(1, 8'h32, 0);
        cyc(1, 8'h33, 0);
        chk("t5_count3", 32'(count), 3);
        cyc(1, 8'h99, 1, 1);
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_valid", 32'(rd_valid), 0);
        chk("t5_udf", 32'(underflow), 1);
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_hold", 32'(rd_data), 32'hAA);
        cyc(1, 8'h77, 0);
        cyc(0, 0, 1);
        chk("t5_readback", 32'(rd_data), 32'h77);

        // reset mid-operation
        cyc(1, 8'h41, 0);
        cyc(1, 8'h42, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst2_count", 32'(count), 0);
        chk("rst2_udf", 32'(underflow), 0);

        // 6: parity
        cyc(1, 8'h5A, 0);
`ifdef FIFO_PARITY_EN
        u_dut.u_mem.mem[0][0] = ~u_dut.u_mem.mem[0][0];
        q[0]  = q[0] ^ 8'h01;
        cq[0] = 1'b1;
        cyc(0, 0, 1);
        chk("t6_valid", 32'(rd_valid), 1);
        chk("t6_perr", 32'(parity_err), 1);
`else
        cyc(0, 0, 1);
        chk("t6_valid", 32'(rd_valid), 1);
        chk("t6_perr", 32'(parity_err), 0);
        chk("t6_data", 32'(rd_data), 32'h5A);
`endif
        cyc(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
